// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: rebuilds W-bit words from a sync-framed serial
// stream and queues them in a 2-entry buffer drained over valid/ready.
module sipo_deframer #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         si,
  input  logic         sync,
  input  logic         out_ready,
  input  logic         clr_err,
  output logic [W-1:0] po,
  output logic         po_valid,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [1:0]    occ_q, occ_d;
  logic          ovr_q, ovr_d, fe_q, fe_d;

  logic [W-1:0]  base, shifted;
  logic          push, pop, drop, resync;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    // A sync restarts assembly from an empty register, whatever was in flight.
    base = (state_q == SHIFT && !sync) ? sr_q : '0;
    if (MSB_FIRST) shifted = {base[W-2:0], si};
    else           shifted = {si, base[W-1:1]};

    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    push    = 1'b0;
    resync  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
          sr_d    = shifted;
        end
      end
      SHIFT: begin
        sr_d = shifted;
        if (sync) begin
          resync = 1'b1;
          cnt_d  = CW'(1);
        end else if (cnt_q == CW'(W - 1)) begin
          push    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pop    = (occ_q != 2'd0) && out_ready;
    drop   = push && (occ_q == 2'd2) && !pop;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;

    unique case (occ_q)
      2'd0: if (push) begin
        head_d = shifted;
        occ_d  = 2'd1;
      end
      2'd1: begin
        if (push && pop)  head_d = shifted;
        else if (push) begin
          tail_d = shifted;
          occ_d  = 2'd2;
        end else if (pop) occ_d = 2'd0;
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = shifted;
          else      occ_d  = 2'd1;
        end
      end
    endcase

    // Set beats clear when both happen in the same cycle.
    ovr_d = (ovr_q & ~clr_err) | drop;
    fe_d  = (fe_q  & ~clr_err) | resync;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  // NOTE: the buffer entries are reset as well, because po must read 0 after
  // reset even though po_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  assign po        = head_q;
  assign po_valid  = (occ_q != 2'd0);
  assign busy      = (state_q == SHIFT);
  assign overrun   = ovr_q;
  assign frame_err = fe_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: a hand-derived vector table plus a behavioural
// scoreboard model checked every cycle, and an LSB-first instance.
module tb_sipo_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       si, sync, out_ready, clr_err;
  logic [3:0] po, lsb_po;
  logic       po_valid, busy, overrun, frame_err;
  logic       lsb_valid, lsb_busy, lsb_ovr, lsb_fe;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sipo_deframer #(.W(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .si(si), .sync(sync), .out_ready(out_ready),
    .clr_err(clr_err), .po(po), .po_valid(po_valid), .busy(busy),
    .overrun(overrun), .frame_err(frame_err)
  );

  sipo_deframer #(.W(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .si(si), .sync(sync), .out_ready(1'b1),
    .clr_err(clr_err), .po(lsb_po), .po_valid(lsb_valid), .busy(lsb_busy),
    .overrun(lsb_ovr), .frame_err(lsb_fe)
  );

  // Scoreboard model of the MSB-first instance.
  logic [3:0] exp_q[$];
  bit         m_shift, m_ov, m_fe;
  int         m_cnt;
  logic [3:0] m_word, m_last;

  typedef struct {
    logic si, sync, rdy, clr;
    logic valid; logic [3:0] po; logic busy, ov, fe;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_shift = 0; m_ov = 0; m_fe = 0; m_cnt = 0; m_word = '0; m_last = '0;
  endtask

  task automatic model_edge(input logic s, input logic sy, input logic rdy, input logic clr);
    bit do_pop, do_push, set_ov, set_fe;
    do_pop = (exp_q.size() != 0) && rdy;
    do_push = 0; set_ov = 0; set_fe = 0;
    if (sy) begin
      if (m_shift) set_fe = 1;
      m_shift = 1; m_cnt = 1; m_word = '0; m_word[3] = s;
    end else if (m_shift) begin
      m_word[3 - m_cnt] = s;
      m_cnt++;
      if (m_cnt == 4) begin do_push = 1; m_shift = 0; m_cnt = 0; end
    end
    if (do_push && exp_q.size() == 2 && !do_pop) begin set_ov = 1; do_push = 0; end
    if (do_pop) m_last = exp_q.pop_front();
    if (do_push) exp_q.push_back(m_word);
    m_ov = (m_ov && !clr) || set_ov;
    m_fe = (m_fe && !clr) || set_fe;
  endtask

  task automatic cycle(input logic s, input logic sy, input logic rdy, input logic clr);
    si = s; sync = sy; out_ready = rdy; clr_err = clr;
    @(posedge clk);
    model_edge(s, sy, rdy, clr);
    #1;
    check("po_valid", po_valid, exp_q.size() != 0);
    check("po", po, (exp_q.size() != 0) ? exp_q[0] : m_last);
    check("busy", busy, m_shift);
    check("overrun", overrun, m_ov);
    check("frame_err", frame_err, m_fe);
  endtask

  task automatic frame(input logic [3:0] bits, input logic rdy);
    for (int k = 0; k < 4; k++) cycle(bits[3-k], k == 0, rdy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Basic word 1010 then back-to-back 1101, out_ready held high.
    tbl[0] = '{1, 1, 1, 0, 0, 4'h0, 1, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 4'h0, 1, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 0, 4'h0, 1, 0, 0};
    tbl[3] = '{0, 0, 1, 0, 1, 4'hA, 0, 0, 0};
    tbl[4] = '{1, 1, 1, 0, 0, 4'hA, 1, 0, 0};
    tbl[5] = '{1, 0, 1, 0, 0, 4'hA, 1, 0, 0};
    tbl[6] = '{0, 0, 1, 0, 0, 4'hA, 1, 0, 0};
    tbl[7] = '{1, 0, 1, 0, 1, 4'hD, 0, 0, 0};
    tbl[8] = '{0, 0, 1, 0, 0, 4'hD, 0, 0, 0};

    rst_n = 1'b0; si = 0; sync = 0; out_ready = 0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_po", po, 4'h0);
    check("reset_valid", po_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_flags", {overrun, frame_err}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].si, tbl[i].sync, tbl[i].rdy, tbl[i].clr);
      check($sformatf("vec%0d_valid", i), po_valid, tbl[i].valid);
      check($sformatf("vec%0d_po", i), po, tbl[i].po);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("vec%0d_flags", i), {overrun, frame_err}, {tbl[i].ov, tbl[i].fe});
    end

    // Backpressure: third word is dropped, head held, then drained.
    frame(4'b1010, 1'b0);
    frame(4'b1101, 1'b0);
    frame(4'b0110, 1'b0);
    check("bp_head", po, 4'b1010);
    check("bp_valid", po_valid, 1'b1);
    check("bp_overrun", overrun, 1'b1);
    cycle(0, 0, 1, 0);
    check("bp_pop1", po, 4'b1101);
    check("bp_pop1_valid", po_valid, 1'b1);
    cycle(0, 0, 1, 0);
    check("bp_drained", po_valid, 1'b0);
    cycle(0, 0, 1, 1);
    check("bp_clr", overrun, 1'b0);

    // Resync mid-word, then clear.
    cycle(1, 1, 1, 0); cycle(1, 0, 1, 0);
    cycle(0, 1, 1, 0); cycle(0, 0, 1, 0); cycle(1, 0, 1, 0); cycle(1, 0, 1, 0);
    check("resync_po", po, 4'b0011);
    check("resync_fe", frame_err, 1'b1);
    cycle(0, 0, 1, 1);
    check("resync_clr", frame_err, 1'b0);

    // Resync with clr_err in the same cycle: set wins.
    cycle(1, 1, 1, 0); cycle(0, 1, 1, 1);
    check("set_beats_clr", frame_err, 1'b1);
    cycle(1, 0, 1, 0); cycle(0, 0, 1, 0); cycle(1, 0, 1, 0);
    check("after_setclr_po", po, 4'b0101);
    cycle(0, 0, 1, 1);

    // Sync coincides with the last bit: resync, no word emitted.
    cycle(1, 1, 1, 0); cycle(0, 0, 1, 0); cycle(1, 0, 1, 0); cycle(0, 1, 1, 0);
    check("late_sync_novalid", po_valid, 1'b0);
    check("late_sync_fe", frame_err, 1'b1);
    cycle(1, 0, 1, 0); cycle(1, 0, 1, 0); cycle(0, 0, 1, 0);
    check("late_sync_po", po, 4'b0110);
    cycle(0, 0, 1, 1);

    // LSB-first instance sees bits 1,0,1,1.
    frame(4'b1011, 1'b1);
    check("lsb_po", lsb_po, 4'b1101);
    check("lsb_valid", lsb_valid, 1'b1);
    check("msb_same_stream", po, 4'b1011);

    // Asynchronous reset two bits into a word.
    cycle(1, 1, 1, 0); cycle(1, 0, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("areset_po", po, 4'h0);
    check("areset_busy", busy, 1'b0);
    check("areset_valid", {po_valid, lsb_valid}, 2'b00);
    check("areset_lsb_po", lsb_po, 4'h0);
    #2 rst_n = 1'b1;
    frame(4'b1010, 1'b1);
    check("post_reset_po", po, 4'b1010);
    check("post_reset_fe", frame_err, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
